// File: rtl/mem_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_dma_pkg
// Description : Shared definitions for the mem_dma word-copy engine: the
//               controller state encoding and the bus word size.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_dma_pkg;

    // Controller states. The width is fixed at two bits so the encoding stays
    // stable for anything that probes the state register.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_WCHK = 2'd3
    } mem_dma_state_e;

    // Bytes per bus word; pointers advance by this amount per copied word.
    localparam int unsigned WORD_BYTES = 4;

endpackage : mem_dma_pkg
`default_nettype wire

// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
// Module      : mem_dma
// Description : Single-channel memory-to-memory word copy engine. Copies
//               'len' 32-bit words from src_addr to dst_addr using a simple
//               read / write / write-check sequence, three cycles per word.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   MEM_DMA_IRQ_EN  defined   : irq is set on done or on a new fault and is
//                               cleared by irq_ack (a set beats a clear).
//                   undefined : irq is tied low and irq_ack is ignored.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low
//   start      in   copy request, sampled only while idle
//   src_addr   in   32  byte address of first source word
//   dst_addr   in   32  byte address of first destination word
//   len        in   LEN_W  number of words to copy
//   busy       out  copy in progress
//   done       out  one-cycle pulse on successful completion
//   error      out  sticky fault flag, cleared by the next accepted start
//   err_addr   out  32  address of the faulting access
//   read       out  bus read strobe
//   write      out  bus write strobe
//   addr       out  32  bus address (zero when no strobe)
//   wdata      out  32  bus write data (zero when no strobe)
//   rdata      in   32  bus read data, valid with read_acc
//   read_acc   in   combinational read acknowledge
//   write_acc  in   registered write acknowledge (cycle after write)
//   irq        out  completion / fault interrupt level
//   irq_ack    in   interrupt clear
// ============================================================================
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      err_addr,
    output logic             read,
    output logic             write,
    output logic [31:0]      addr,
    output logic [31:0]      wdata,
    input  logic [31:0]      rdata,
    input  logic             read_acc,
    input  logic             write_acc,
    output logic             irq,
    input  logic             irq_ack
);

    localparam logic [31:0] c_ptr_step = 32'(WORD_BYTES);

    mem_dma_state_e   r_state;
    logic [31:0]      r_src_ptr;
    logic [31:0]      r_dst_ptr;
    logic [LEN_W-1:0] r_cnt;
    logic [31:0]      r_buf;
    logic             r_error;
    logic [31:0]      r_err_addr;
    logic             r_done_zero;   // done pulse for a zero-length request

    logic [LEN_W-1:0] w_cnt_next;
    logic             w_src_misaligned;
    logic             w_dst_misaligned;
    logic             w_done_copy;

    assign w_cnt_next       = r_cnt - LEN_W'(1);
    assign w_src_misaligned = (src_addr[1:0] != 2'b00);
    assign w_dst_misaligned = (dst_addr[1:0] != 2'b00);

    // The write acknowledge arrives while in WCHK, so the completion pulse is
    // decoded from it directly; this keeps the copy at exactly three cycles
    // per word with done landing in the last WCHK cycle.
    assign w_done_copy = (r_state == ST_WCHK) && write_acc && (w_cnt_next == '0);

    // ------------------------------------------------------------------------
    // Controller and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_error     <= 1'b0;
            r_err_addr  <= '0;
            r_done_zero <= 1'b0;
        end else begin
            r_done_zero <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_src_ptr <= src_addr;
                        r_dst_ptr <= dst_addr;
                        r_cnt     <= len;
                        r_error   <= 1'b0;
                        // Alignment faults take priority over a zero length;
                        // source is reported ahead of destination.
                        if (w_src_misaligned) begin
                            r_error    <= 1'b1;
                            r_err_addr <= src_addr;
                        end else if (w_dst_misaligned) begin
                            r_error    <= 1'b1;
                            r_err_addr <= dst_addr;
                        end else if (len == '0) begin
                            r_done_zero <= 1'b1;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (read_acc) begin
                        r_buf   <= rdata;
                        r_state <= ST_WR;
                    end else begin
                        r_error    <= 1'b1;
                        r_err_addr <= r_src_ptr;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    r_state <= ST_WCHK;
                end
                ST_WCHK: begin
                    if (write_acc) begin
                        r_cnt     <= w_cnt_next;
                        r_src_ptr <= r_src_ptr + c_ptr_step;
                        r_dst_ptr <= r_dst_ptr + c_ptr_step;
                        r_state   <= (w_cnt_next != '0) ? ST_RD : ST_IDLE;
                    end else begin
                        r_error    <= 1'b1;
                        r_err_addr <= r_dst_ptr;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Bus outputs are decoded from the state register so they fall to zero
    // together with it on an asynchronous reset.
    // ------------------------------------------------------------------------
    always_comb begin
        read  = 1'b0;
        write = 1'b0;
        addr  = '0;
        wdata = '0;
        case (r_state)
            ST_RD: begin
                read = 1'b1;
                addr = r_src_ptr;
            end
            ST_WR: begin
                write = 1'b1;
                addr  = r_dst_ptr;
                wdata = r_buf;
            end
            default: begin
            end
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done_zero | w_done_copy;
    assign error    = r_error;
    assign err_addr = r_err_addr;

    // ------------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------------
`ifdef MEM_DMA_IRQ_EN
    logic r_irq;
    logic w_err_set;

    // Every event that raises error on the coming edge.
    assign w_err_set = ((r_state == ST_IDLE) && start && (w_src_misaligned || w_dst_misaligned))
                     || ((r_state == ST_RD)   && !read_acc)
                     || ((r_state == ST_WCHK) && !write_acc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else if (done || w_err_set) begin
            r_irq <= 1'b1;
        end else if (irq_ack) begin
            r_irq <= 1'b0;
        end
    end

    // The done term lets irq rise in the same cycle as the done pulse.
    assign irq = r_irq | done;
`else
    logic w_unused_irq_ack;

    assign w_unused_irq_ack = irq_ack;
    assign irq              = 1'b0;
`endif

endmodule : mem_dma
`default_nettype wire

// File: tb/tb_mem_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_dma
// Description : Self-checking bench for mem_dma. A directed table plus
//               random copies, each compared against a word-level reference
//               model of the copy, and hand-written reset / busy-start / irq
//               sequences. Bus slave: reads and writes in 0x100..0x1FF are
//               not acknowledged; all other addresses are backed by memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dma;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, error, read, write, irq;
    logic [31:0]      err_addr, addr, wdata;
    logic [31:0]      rdata = '0;
    logic             read_acc = 1'b0;
    logic             write_acc;
    logic             irq_ack = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem   [bit [31:0]];
    logic [31:0] exp_w [bit [31:0]];

    typedef struct {
        logic        err;
        logic [31:0] ea;
        int          done_c;
        int          end_c;
        int          rd;
        int          wr;
    } res_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        res_t        e;
    } vec_t;

    mem_dma #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_addr  (err_addr),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .read_acc  (read_acc),
        .write_acc (write_acc),
        .irq       (irq),
        .irq_ack   (irq_ack)
    );

    always #5 clk = ~clk;

    function automatic bit unmapped(input logic [31:0] a);
        return (a >= 32'h100) && (a < 32'h200);
    endfunction

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    // Bus slave: read response settles mid-cycle, ahead of the sampling edge.
    always @(negedge clk) begin
        read_acc = read && !unmapped(addr);
        rdata    = (read && !unmapped(addr)) ? mem_get(addr) : 32'h0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_acc <= 1'b0;
        end else begin
            write_acc <= write && !unmapped(addr);
            if (write && !unmapped(addr)) mem[addr] = wdata;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] s, input logic [31:0] d, input int n,
                                 input bit err, input logic [31:0] ea, input int dc,
                                 input int ec, input int rd, input int wr);
        vec_t v;
        v.src = s; v.dst = d; v.len = 16'(n);
        v.e.err = err; v.e.ea = ea; v.e.done_c = dc; v.e.end_c = ec;
        v.e.rd = rd; v.e.wr = wr;
        return v;
    endfunction

    // Word-level model: walk the copy word by word, stop at the first fault.
    // Cycle n of the request: start is in cycle 0, each word spans 3 cycles.
    task automatic model(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         output res_t r);
        int          nn;
        logic [31:0] sa, da, val;
        exp_w.delete();
        nn = int'(n);
        r.err = 1'b0; r.ea = '0; r.done_c = 0; r.end_c = 1; r.rd = 0; r.wr = 0;
        if (s[1:0] != 2'b00) begin r.err = 1'b1; r.ea = s; return; end
        if (d[1:0] != 2'b00) begin r.err = 1'b1; r.ea = d; return; end
        if (nn == 0) begin r.done_c = 1; return; end
        for (int i = 0; i < nn; i++) begin
            sa = s + 32'(4 * i);
            da = d + 32'(4 * i);
            if (unmapped(sa)) begin
                r.err = 1'b1; r.ea = sa; r.end_c = 3 * i + 2; r.rd = i + 1; r.wr = i;
                return;
            end
            val = exp_w.exists(sa) ? exp_w[sa] : mem_get(sa);
            if (unmapped(da)) begin
                r.err = 1'b1; r.ea = da; r.end_c = 3 * i + 4; r.rd = i + 1; r.wr = i + 1;
                return;
            end
            exp_w[da] = val;
        end
        r.done_c = 3 * nn;
        r.end_c  = 3 * nn + 1;
        r.rd     = nn;
        r.wr     = nn;
    endtask

    // Runs one request. intr_c: cycle whose closing edge sees an extra start
    // (misaligned) while busy. ack_c: cycle whose closing edge sees irq_ack.
    task automatic run_copy(input vec_t vin, input bit use_model, input int intr_c, input int ack_c);
        vec_t v;
        res_t mr;
        int   done_c, done_n, end_c, rd_n, wr_n;
        logic err_s;
        v = vin;
        model(v.src, v.dst, v.len, mr);
        if (use_model) v.e = mr;
        done_c = 0; done_n = 0; end_c = 0; rd_n = 0; wr_n = 0; err_s = 1'b0;
        @(negedge clk);
        start = 1'b1; src_addr = v.src; dst_addr = v.dst; len = v.len;
        for (int k = 1; k <= v.e.end_c + 3; k++) begin
            @(negedge clk);
            if (done) begin
                done_n++;
                if (done_c == 0) done_c = k;
`ifdef MEM_DMA_IRQ_EN
                check("irq_with_done", 64'(irq), 64'd1);
`endif
            end
            if (!busy && end_c == 0) end_c = k;
            if (read)  rd_n++;
            if (write) wr_n++;
            check("rd_wr_exclusive", 64'(read && write), 64'd0);
            if (!read && !write) check("idle_bus_zero", {addr, wdata}, 64'd0);
`ifndef MEM_DMA_IRQ_EN
            check("irq_tied_low", 64'(irq), 64'd0);
`endif
            err_s = error;
            start = (k == intr_c);
            if (k == intr_c) begin
                src_addr = 32'h2; dst_addr = 32'h0; len = 16'd1;
            end
            irq_ack = (k == ack_c);
        end
        start = 1'b0; irq_ack = 1'b0;
        check("error",      64'(err_s), 64'(v.e.err));
        if (v.e.err) check("err_addr", 64'(err_addr), 64'(v.e.ea));
        check("done_count", 64'(done_n), (v.e.done_c != 0) ? 64'd1 : 64'd0);
        check("done_cycle", 64'(done_c), 64'(v.e.done_c));
        check("busy_end",   64'(end_c),  64'(v.e.end_c));
        check("read_strobes",  64'(rd_n), 64'(v.e.rd));
        check("write_strobes", 64'(wr_n), 64'(v.e.wr));
        foreach (exp_w[a]) check("dst_word", 64'(mem_get(a)), 64'(exp_w[a]));
`ifdef MEM_DMA_IRQ_EN
        if (v.e.err && ack_c == 0) check("irq_on_error", 64'(irq), 64'd1);
`endif
    endtask

    vec_t tbl [9];

    initial begin
        logic [31:0] s, d;
        int          l, r;

        mem[32'h0] = 32'h11;
        mem[32'h4] = 32'h22;
        mem[32'h8] = 32'h33;

        tbl[0] = mkv(32'h0,        32'h20,       3, 1'b0, 32'h0,   9, 10, 3, 3);
        tbl[1] = mkv(32'h0,        32'h3FFFFFFC, 1, 1'b0, 32'h0,   3,  4, 1, 1);
        tbl[2] = mkv(32'h100,      32'h40,       2, 1'b1, 32'h100, 0,  2, 1, 0);
        tbl[3] = mkv(32'h2,        32'h40,       4, 1'b1, 32'h2,   0,  1, 0, 0);
        tbl[4] = mkv(32'h0,        32'h42,       1, 1'b1, 32'h42,  0,  1, 0, 0);
        tbl[5] = mkv(32'h0,        32'h40,       0, 1'b0, 32'h0,   1,  1, 0, 0);
        tbl[6] = mkv(32'h0,        32'hF8,       4, 1'b1, 32'h100, 0, 10, 3, 3);
        tbl[7] = mkv(32'h10,       32'hFFFFFFF8, 3, 1'b0, 32'h0,   9, 10, 3, 3);
        tbl[8] = mkv(32'hFFFFFFFC, 32'h300,      2, 1'b0, 32'h0,   6,  7, 2, 2);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_ctrl", {58'd0, busy, done, error, irq, read, write}, 64'd0);
        check("reset_bus",  {addr, wdata}, 64'd0);
        check("reset_err_addr", 64'(err_addr), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_copy(tbl[i], 1'b0, 0, 0);
            if (i == 0) begin
                check("copy_w8",  64'(mem_get(32'h20)), 64'h11);
                check("copy_w9",  64'(mem_get(32'h24)), 64'h22);
                check("copy_w10", 64'(mem_get(32'h28)), 64'h33);
            end
            if (i == 1) check("stack_top", 64'(mem_get(32'h3FFFFFFC)), 64'h11);
        end

        // Start while busy is ignored
        run_copy(mkv(32'h0, 32'h60, 2, 1'b0, 32'h0, 0, 0, 0, 0), 1'b1, 2, 0);

        // Reset asserted in WR aborts the copy, then a fresh copy works
        @(negedge clk);
        start = 1'b1; src_addr = 32'h0; dst_addr = 32'h80; len = 16'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("wr_before_reset", 64'(write), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("abort_ctrl", {58'd0, busy, done, error, irq, read, write}, 64'd0);
        check("abort_bus",  {addr, wdata}, 64'd0);
        check("abort_err_addr", 64'(err_addr), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_copy(mkv(32'h0, 32'h80, 3, 1'b0, 32'h0, 0, 0, 0, 0), 1'b1, 0, 0);

        // Interrupt behaviour
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        check("irq_after_ack", 64'(irq), 64'd0);
        run_copy(mkv(32'h0, 32'h240, 1, 1'b0, 32'h0, 0, 0, 0, 0), 1'b1, 0, 0);
`ifdef MEM_DMA_IRQ_EN
        check("irq_held", 64'(irq), 64'd1);
`else
        check("irq_held", 64'(irq), 64'd0);
`endif
        run_copy(mkv(32'h4, 32'h244, 1, 1'b0, 32'h0, 0, 0, 0, 0), 1'b1, 0, 3);
`ifdef MEM_DMA_IRQ_EN
        check("irq_set_beats_ack", 64'(irq), 64'd1);
`else
        check("irq_set_beats_ack", 64'(irq), 64'd0);
`endif
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        check("irq_cleared", 64'(irq), 64'd0);

        // Random copies against the model
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            s = 32'($urandom_range(0, 255)) << 2;
            d = 32'($urandom_range(0, 255)) << 2;
            l = int'($urandom_range(0, 6));
            if (r == 0) s = 32'hFFFFFFF0 + (32'($urandom_range(0, 3)) << 2);
            if (r == 1) d = 32'hFFFFFFF0 + (32'($urandom_range(0, 3)) << 2);
            if (r == 2) s[1:0] = 2'($urandom_range(1, 3));
            if (r == 3) d[1:0] = 2'($urandom_range(1, 3));
            if ((r == 2 || r == 3) && l == 0) l = 1;
            run_copy(mkv(s, d, l, 1'b0, 32'h0, 0, 0, 0, 0), 1'b1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_dma
`default_nettype wire
